cmd_frame_ctrl: RTL and testbench
=================================

# cmd_frame_ctrl

Sequencer for the command-frame parser on the control FIFO path. It waits until the command FIFO holds a complete frame, then runs one parse via the parser's fs/fd handshake and samples the parser's error flag. Good frames are handed to the configuration consumer with a valid/ready handshake. Bad or timed-out frames are drained from the FIFO and counted.

## Interface
Parameters:
- DATA_LEN, 12'd12: frame length in bytes; driven unchanged on `data_len`.
- TIMEOUT, 1024: maximum cycles allowed from fs rise to fd rise.
- CNT_W, 8: width of the error counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  allows new frames to start; a frame already in progress always completes.
- fifoc_cnt  in  12  bytes currently held in the command FIFO.
- fifoc_empty  in  1  command FIFO empty.
- drain_rxen  out  1  FIFO read strobe used for discarding bytes; ORed with the parser's rxen at top level.
- ps_fs  out  1  parser start; level signal, held until fd is seen.
- ps_fd  in  1  parser done; level signal.
- ps_err  in  1  parser error; valid while ps_fd=1.
- data_len  out  12  constant DATA_LEN.
- cfg_valid  out  1  parsed configuration is ready for the consumer.
- cfg_ready  in  1  consumer accepts the configuration.
- busy  out  1  state is not IDLE and not WAIT.
- frame_ok_cnt  out  16  count of good frames; wraps.
- frame_err_cnt  out  CNT_W  count of parser errors; saturates at all-ones.
- timeout_cnt  out  CNT_W  count of timeouts; saturates at all-ones.

## Operation
- States: IDLE, WAIT, START, STOP, CFG, DRAIN. One-hot or binary encoding is allowed.
- IDLE: moves to WAIT when enable=1.
- WAIT:
  - enable=0 → IDLE.
  - fifoc_cnt ≥ DATA_LEN → START.
  - fifoc_cnt = DATA_LEN−1 → stays in WAIT.
- START:
  - ps_fs=1 and the watchdog increments each cycle.
  - On ps_fd=1: latch ps_err into err_l, then → STOP.
  - Watchdog reaches TIMEOUT−1 with ps_fd still 0: timeout_cnt++, set err_l=1, then → STOP.
- STOP:
  - ps_fs=0; waits for ps_fd=0.
  - err_l=0 → CFG, frame_ok_cnt++.
  - err_l=1 → DRAIN; frame_err_cnt++ unless the error was a timeout.
- CFG:
  - cfg_valid=1, held until cfg_ready=1.
  - On acceptance: enable=1 → WAIT, enable=0 → IDLE.
- DRAIN:
  - drain_rxen = !fifoc_empty.
  - Exits when fifoc_empty=1; enable=1 → WAIT, enable=0 → IDLE.
- All outputs (ps_fs, drain_rxen, cfg_valid, busy) are decoded from the registered state. There are no combinational paths from inputs to outputs.
- Saturating counters hold at all-ones. frame_ok_cnt wraps from 16'hFFFF to 0.

## Timing
- Reset values:
  - State = IDLE.
  - ps_fs, drain_rxen, cfg_valid, busy = 0.
  - All counters and err_l = 0.
  - data_len = DATA_LEN.
- Asserting rst mid-frame drops ps_fs immediately (asynchronous reset). The parser then returns to idle on its own.
- fifoc_cnt reaching the threshold in cycle N: ps_fs=1 in cycle N+1.
- ps_fd first seen high in cycle M: ps_fs=0 in cycle M+1.
- ps_fd seen low in STOP at cycle K: cfg_valid=1 (or drain_rxen) in cycle K+1.
- cfg_valid and cfg_ready both high in the same cycle: transfer completes; cfg_valid=0 in the next cycle.
- DRAIN entered with the FIFO already empty: one cycle in DRAIN, zero reads.
- enable falling while in START, STOP, CFG or DRAIN has no effect until the frame finishes.
- ps_fd already high on entry to START (stale level): ignored for the first cycle of START. Only an fd observed at watchdog count ≥1 is accepted.
- The watchdog clears on every entry to START.

## Structure
- Shared package `cmd_pkg` holds:
  - state localparams;
  - DATA_LEN default (12);
  - frame header constant 16'h55AA;
  - ERR/OK codes.
- One sub-module, `sat_cnt` (parameterised width, inc, clr, saturating output), used for frame_err_cnt and timeout_cnt.
- The watchdog is an inline counter.
- Expected size: 150–250 lines.

## Test plan
- Good frame: preload 12 valid bytes, enable=1, cfg_ready=1.
  - Required: ps_fs high 1 cycle after cnt=12; cfg_valid pulses once; frame_ok_cnt=1; drain_rxen never asserts.
- Bad checksum: parser returns err=1.
  - Required: DRAIN reads exactly the remaining bytes until empty; frame_err_cnt=1; cfg_valid stays 0.
- Backpressure: cfg_ready held low 20 cycles.
  - Required: cfg_valid stays high for 20 cycles and drops the cycle after cfg_ready=1; no second frame starts meanwhile.
- Timeout: stub parser never raises fd, TIMEOUT=16.
  - Required: ps_fs falls after 16 cycles; timeout_cnt=1; DRAIN empties the FIFO.
- Threshold and enable: fifoc_cnt=11 gives no start; enable cleared mid-frame.
  - Required: frame completes, then state goes to IDLE; 300 forced errors leave frame_err_cnt=8'hFF.
- Reset during START: ps_fs=0 asynchronously; all counters read 0.

Source files
------------

// File: rtl/cmd_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command-frame sequencer on the control FIFO path.
//   state_t       : sequencer states (also exported on the debug port)
//   DATA_LEN_DEF  : default frame length in bytes
//   FRAME_HDR     : command frame header word recognised by the parser
//   OK_CODE/ERR_CODE : values held in the frame error latch
// -----------------------------------------------------------------------------
package cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_STOP  = 3'd3,
    ST_CFG   = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  localparam logic [11:0] DATA_LEN_DEF = 12'd12;
  localparam logic [15:0] FRAME_HDR    = 16'h55AA;

  localparam logic OK_CODE  = 1'b0;
  localparam logic ERR_CODE = 1'b1;

endpackage

// File: rtl/cmd_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// cmd_frame_ctrl_if
// Bus bundle between the frame sequencer and its neighbours.
//   FIFO side   : fifoc_cnt, fifoc_empty (to sequencer), drain_rxen (from it)
//   Parser side : ps_fs (from sequencer), ps_fd, ps_err (to it), data_len
//   Config side : cfg_valid (from sequencer), cfg_ready (to it)
//
// Handshake rules:
//   cfg_valid/cfg_ready - a transfer happens on a rising clk edge where both
//     are high. Once raised, cfg_valid stays high until that transfer; the
//     consumer may hold cfg_ready low for any number of cycles.
//   ps_fs/ps_fd - level handshake. ps_fs rises to start a parse and is held
//     until ps_fd is seen high; ps_err is only meaningful while ps_fd is high.
//     ps_fd returns low after ps_fs drops.
// Modports: master = sequencer side, slave = environment side.
// -----------------------------------------------------------------------------
interface cmd_frame_ctrl_if;

  logic [11:0] fifoc_cnt;
  logic        fifoc_empty;
  logic        drain_rxen;

  logic        ps_fs;
  logic        ps_fd;
  logic        ps_err;
  logic [11:0] data_len;

  logic        cfg_valid;
  logic        cfg_ready;

  modport master (
    input  fifoc_cnt, fifoc_empty, ps_fd, ps_err, cfg_ready,
    output drain_rxen, ps_fs, data_len, cfg_valid
  );

  modport slave (
    output fifoc_cnt, fifoc_empty, ps_fd, ps_err, cfg_ready,
    input  drain_rxen, ps_fs, data_len, cfg_valid
  );

endinterface

// File: rtl/cmd_frame_ctrl_sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
// Saturating up-counter: clears on clr, increments on inc, holds at all-ones.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count enable
//   q        : counter value
// -----------------------------------------------------------------------------
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// -----------------------------------------------------------------------------
// cmd_frame_ctrl
// Sequencer for the command-frame parser. Waits for a complete frame in the
// command FIFO, runs one parse through the fs/fd handshake, then either hands
// the configuration to the consumer (good frame) or drains the FIFO (parser
// error or watchdog timeout), keeping frame statistics.
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : allows new frames to start; a running frame always finishes
//   bus (master)  : FIFO, parser and config signals (see cmd_frame_ctrl_if)
//   busy          : a frame is in progress (state not IDLE/WAIT)
//   frame_ok_cnt  : good frames, wraps
//   frame_err_cnt : parser errors, saturating
//   timeout_cnt   : watchdog timeouts, saturating
//   state_dbg     : current sequencer state
// -----------------------------------------------------------------------------
module cmd_frame_ctrl
  import cmd_pkg::*;
#(
  parameter logic [11:0] DATA_LEN = DATA_LEN_DEF,
  parameter int          TIMEOUT  = 1024,
  parameter int          CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  cmd_frame_ctrl_if.master  bus,
  output logic              busy,
  output logic [15:0]       frame_ok_cnt,
  output logic [CNT_W-1:0]  frame_err_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output state_t            state_dbg
);

  // One spare bit so the watchdog never wraps before reaching TIMEOUT-1.
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_l_q, err_l_d;   // frame failed (parser error or timeout)
  logic            to_l_q, to_l_d;     // failure was a timeout
  logic            inc_ok, inc_err, inc_to;

  // ---------------------------------------------------------------------------
  // State and frame registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wd_q         <= '0;
      err_l_q      <= OK_CODE;
      to_l_q       <= 1'b0;
      frame_ok_cnt <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_l_q <= err_l_d;
      to_l_q  <= to_l_d;
      if (inc_ok) begin
        frame_ok_cnt <= frame_ok_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_l_d = err_l_q;
    to_l_d  = to_l_q;
    inc_ok  = 1'b0;
    inc_err = 1'b0;
    inc_to  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (bus.fifoc_cnt >= DATA_LEN) begin
          // Fresh watchdog and error latches for every frame.
          state_d = ST_START;
          wd_d    = '0;
          err_l_d = OK_CODE;
          to_l_d  = 1'b0;
        end
      end

      ST_START: begin
        wd_d = wd_q + 1'b1;
        // An fd level seen in the first START cycle belongs to the previous
        // parse, so completion is only accepted once the watchdog has moved.
        if (bus.ps_fd && (wd_q != '0)) begin
          err_l_d = bus.ps_err;
          state_d = ST_STOP;
        end else if (wd_q == WD_LAST) begin
          err_l_d = ERR_CODE;
          to_l_d  = 1'b1;
          inc_to  = 1'b1;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        // fs is already low here; wait for the parser to release fd.
        if (!bus.ps_fd) begin
          if (err_l_q == OK_CODE) begin
            state_d = ST_CFG;
            inc_ok  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            inc_err = !to_l_q;
          end
        end
      end

      ST_CFG: begin
        if (bus.cfg_ready) begin
          state_d = enable ? ST_WAIT : ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (bus.fifoc_empty) begin
          state_d = enable ? ST_WAIT : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state. The drain strobe is also
  // qualified by fifoc_empty so a read is never issued against an empty FIFO;
  // this keeps an empty-on-entry drain at zero reads.
  // ---------------------------------------------------------------------------
  assign bus.ps_fs      = (state_q == ST_START);
  assign bus.cfg_valid  = (state_q == ST_CFG);
  assign bus.drain_rxen = (state_q == ST_DRAIN) && !bus.fifoc_empty;
  assign bus.data_len   = DATA_LEN;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_WAIT);
  assign state_dbg      = state_q;

  // ---------------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------------
  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (inc_err),
    .q   (frame_err_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_to_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (inc_to),
    .q   (timeout_cnt)
  );

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_ctrl
// Bench for cmd_frame_ctrl with a byte-count FIFO model and a parser stub.
// Each frame's expected outcome (config handed over, or drained with N reads)
// is queued when the frame is loaded and compared when the DUT finishes it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmd_frame_ctrl;
  import cmd_pkg::*;

  localparam int         TIMEOUT = 16;
  localparam int         CNT_W   = 8;
  localparam int         DLEN    = 12;
  localparam logic [3:0] EV_OK   = 4'h1;
  localparam logic [3:0] EV_ERR  = 4'h2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             busy;
  logic [15:0]      frame_ok_cnt;
  logic [CNT_W-1:0] frame_err_cnt;
  logic [CNT_W-1:0] timeout_cnt;
  state_t           state_dbg;

  cmd_frame_ctrl_if bus ();

  cmd_frame_ctrl #(
    .DATA_LEN (12'd12),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bus           (bus),
    .busy          (busy),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt),
    .timeout_cnt   (timeout_cnt),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;

  int          cyc = 0;
  int          fifo_bytes = 0;
  int          load_left = 0;
  int          thr_cyc = 0;
  int          fs_rise_cyc = 0;
  int          fs_hi = 0;
  int          cfg_hi = 0;
  int          cfg_hold = 0;
  int          rd_total = 0;
  logic [11:0] drain_cnt = '0;
  logic        fs_s = 1'b0;
  logic        fs_prev = 1'b0;
  logic        rd_s = 1'b0;
  logic        cfg_s = 1'b0;

  // parser stub controls
  int          stub_cnt = 0;
  int          stub_lat = 1;
  int          stub_consume = DLEN;
  logic        stub_err = 1'b0;
  logic        stub_never = 1'b0;

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [15:0] act);
    if (exp_q.size() == 0) begin
      check({tag, "_extra"}, exp_q.size(), 1);
    end else begin
      check(tag, act, exp_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic fifo_drive(input int prev);
    if (prev < DLEN && fifo_bytes >= DLEN) thr_cyc = cyc + 1;
    bus.fifoc_cnt   = fifo_bytes[11:0];
    bus.fifoc_empty = (fifo_bytes == 0);
  endtask

  task automatic preload(input int n);
    int prev;
    prev = fifo_bytes;
    fifo_bytes += n;
    fifo_drive(prev);
  endtask

  // Sampled on the falling edge, mid-cycle.
  task automatic monitor();
    cyc++;
    fs_s  = bus.ps_fs;
    rd_s  = bus.drain_rxen;
    cfg_s = bus.cfg_valid;
    if (bus.ps_fs) begin
      fs_hi++;
      if (!fs_prev) fs_rise_cyc = cyc;
    end
    fs_prev = bus.ps_fs;
    if (bus.cfg_valid) cfg_hi++;
    if (bus.cfg_valid && !bus.cfg_ready) cfg_hold++;
    if (bus.drain_rxen) begin
      drain_cnt++;
      rd_total++;
    end
    if (bus.cfg_valid && bus.cfg_ready) sb_pop("sb_cfg", {EV_OK, 12'd0});
    if (state_dbg == ST_DRAIN && bus.fifoc_empty) begin
      sb_pop("sb_drain", {EV_ERR, drain_cnt});
      drain_cnt = '0;
    end
  endtask

  // FIFO and parser stub, updated just after the rising edge.
  task automatic model_update();
    int prev;
    prev = fifo_bytes;
    if (load_left > 0) begin
      fifo_bytes++;
      load_left--;
    end
    if (rd_s && fifo_bytes > 0) fifo_bytes--;
    if (fs_s) begin
      if (!bus.ps_fd) begin
        stub_cnt++;
        if (!stub_never && stub_cnt >= stub_lat) begin
          bus.ps_fd  = 1'b1;
          bus.ps_err = stub_err;
          fifo_bytes = (fifo_bytes > stub_consume) ? fifo_bytes - stub_consume : 0;
        end
      end
    end else begin
      stub_cnt   = 0;
      bus.ps_fd  = 1'b0;
      bus.ps_err = 1'b0;
    end
    fifo_drive(prev);
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    check({tag, "_done"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_fs(input int max, input string tag);
    int n;
    n = 0;
    while (!fs_prev && n < max) begin
      cycle();
      n++;
    end
    check({tag, "_fs_seen"}, fs_prev, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int fs0, cfg0, rd0, hold0, n;
    rst             = 1'b1;
    enable          = 1'b0;
    bus.cfg_ready   = 1'b0;
    bus.ps_fd       = 1'b0;
    bus.ps_err      = 1'b0;
    bus.fifoc_cnt   = '0;
    bus.fifoc_empty = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // reset state
    check("rst_fs", bus.ps_fs, 0);
    check("rst_rxen", bus.drain_rxen, 0);
    check("rst_cfg_valid", bus.cfg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ok_cnt", frame_ok_cnt, 0);
    check("rst_err_cnt", frame_err_cnt, 0);
    check("rst_to_cnt", timeout_cnt, 0);
    check("rst_data_len", bus.data_len, DLEN);
    check("rst_state", state_dbg, ST_IDLE);

    // good frame, bytes trickle in one per cycle
    enable = 1'b1;
    bus.cfg_ready = 1'b1;
    cfg0 = cfg_hi;
    rd0  = rd_total;
    exp_q.push_back({EV_OK, 12'd0});
    load_left = DLEN;
    wait_done(100, "good");
    check("good_fs_latency", fs_rise_cyc - thr_cyc, 1);
    check("good_cfg_pulse", cfg_hi - cfg0, 1);
    check("good_ok_cnt", frame_ok_cnt, 1);
    check("good_no_drain", rd_total - rd0, 0);

    // parser error: 5 bytes consumed by the parser, the rest drained
    stub_err     = 1'b1;
    stub_consume = 5;
    cfg0 = cfg_hi;
    exp_q.push_back({EV_ERR, 12'd11});
    preload(16);
    wait_done(200, "bad");
    check("bad_err_cnt", frame_err_cnt, 1);
    check("bad_no_cfg", cfg_hi - cfg0, 0);
    check("bad_fifo_empty", fifo_bytes, 0);
    check("bad_ok_cnt", frame_ok_cnt, 1);

    // backpressure: cfg_ready low for 20 cycles, second frame waiting
    stub_err      = 1'b0;
    stub_consume  = DLEN;
    bus.cfg_ready = 1'b0;
    exp_q.push_back({EV_OK, 12'd0});
    exp_q.push_back({EV_OK, 12'd0});
    hold0 = cfg_hold;
    preload(DLEN);
    n = 0;
    while (!cfg_s && n < 100) begin
      cycle();
      n++;
    end
    check("bp_cfg_seen", cfg_s, 1);
    fs0 = fs_hi;
    preload(DLEN);
    repeat (19) cycle();
    check("bp_hold_cycles", cfg_hold - hold0, 20);
    check("bp_no_second_start", fs_hi - fs0, 0);
    bus.cfg_ready = 1'b1;
    cycle();
    cycle();
    check("bp_valid_drop", cfg_s, 0);
    wait_done(100, "bp");
    check("bp_ok_cnt", frame_ok_cnt, 3);

    // timeout: parser never answers
    stub_never = 1'b1;
    fs0 = fs_hi;
    exp_q.push_back({EV_ERR, 12'd15});
    preload(15);
    wait_done(200, "to");
    check("to_fs_len", fs_hi - fs0, TIMEOUT);
    check("to_cnt", timeout_cnt, 1);
    check("to_err_cnt_same", frame_err_cnt, 1);
    check("to_fifo_empty", fifo_bytes, 0);
    stub_never = 1'b0;

    // one byte short of a frame: no start
    fs0 = fs_hi;
    preload(DLEN - 1);
    repeat (30) cycle();
    check("thr_no_start", fs_hi - fs0, 0);
    check("thr_state_wait", state_dbg, ST_WAIT);

    // enable dropped mid-frame: frame completes, then IDLE
    exp_q.push_back({EV_OK, 12'd0});
    preload(1);
    wait_fs(20, "en");
    enable = 1'b0;
    wait_done(100, "en");
    cycle();
    cycle();
    check("en_idle", state_dbg, ST_IDLE);
    check("en_ok_cnt", frame_ok_cnt, 4);
    fs0 = fs_hi;
    preload(DLEN);
    repeat (10) cycle();
    check("en_off_no_start", fs_hi - fs0, 0);
    fifo_bytes = 0;
    fifo_drive(0);

    // 300 parser errors, FIFO already empty on DRAIN entry
    enable       = 1'b1;
    stub_err     = 1'b1;
    stub_consume = DLEN;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back({EV_ERR, 12'd0});
      preload(DLEN);
      wait_done(60, "ferr");
    end
    check("ferr_sat", frame_err_cnt, 8'hFF);
    check("ferr_to_same", timeout_cnt, 1);

    // asynchronous reset during START
    stub_err = 1'b0;
    stub_lat = 8;
    preload(DLEN);
    wait_fs(20, "rst");
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_fs", bus.ps_fs, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ok_cnt", frame_ok_cnt, 0);
    check("rstmid_err_cnt", frame_err_cnt, 0);
    check("rstmid_to_cnt", timeout_cnt, 0);
    enable = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    fifo_bytes = 0;
    fifo_drive(0);
    cycle();
    check("rstmid_state", state_dbg, ST_IDLE);
    check("rstmid_fd_released", bus.ps_fd, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
